// File: rtl/mac4_accumulator.sv
// Multiply-accumulate controller around an external combinational 4x4 multiplier.
// Registers operand pairs onto the multiplier and sums COUNT products per result frame.
module mac4_accumulator #(
  parameter int COUNT = 16,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] COUNT_C = CW'(COUNT);
  localparam logic [CW-1:0] LAST_C  = CW'(COUNT - 1);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    issued_q, issued_d;
  logic [CW-1:0]    done_cnt_q, done_cnt_d;
  logic             op_valid_q, op_valid_d;
  logic [3:0]       mul_a_q, mul_a_d;
  logic [3:0]       mul_b_q, mul_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             handshake;
  logic [ACC_W:0]   sum_ext;

  assign in_ready  = !rst && !clr && (state_q == ST_ACC) && (issued_q < COUNT_C);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  // Extra top bit captures the carry out of the accumulator width.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_p};

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    done_cnt_d  = done_cnt_q;
    op_valid_d  = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      mul_a_d    = a;
      mul_b_d    = b;
      op_valid_d = 1'b1;
      issued_d   = issued_q + 1'b1;
    end

    if (op_valid_q) begin
      acc_d      = sum_ext[ACC_W-1:0];
      ovf_d      = ovf_q | sum_ext[ACC_W];
      done_cnt_d = done_cnt_q + 1'b1;
      if (done_cnt_q == LAST_C) begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
      end
    end

    // Handshake only happens in DONE, where no accept or accumulate is possible.
    if (handshake) begin
      acc_d       = '0;
      ovf_d       = 1'b0;
      issued_d    = '0;
      done_cnt_d  = '0;
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= ST_ACC;
      issued_q    <= '0;
      done_cnt_q  <= '0;
      op_valid_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      done_cnt_q  <= done_cnt_d;
      op_valid_q  <= op_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac4_accumulator.sv
// Directed bench for mac4_accumulator: default 12-bit and 10-bit accumulator instances in lockstep.
// Frame vectors come from a table; reset/clear corner cases are hand-written sequences.
module tb_mac4_accumulator;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [3:0]  a, b;
  logic        in_ready, out_valid, overflow;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic [11:0] out_sum;
  logic        in_ready10, out_valid10, overflow10;
  logic [3:0]  mul_a10, mul_b10;
  logic [7:0]  mul_p10;
  logic [9:0]  out_sum10;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational array multiplier.
  assign mul_p   = 8'(mul_a) * 8'(mul_b);
  assign mul_p10 = 8'(mul_a10) * 8'(mul_b10);

  mac4_accumulator #(.COUNT(16), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .overflow(overflow)
  );

  mac4_accumulator #(.COUNT(16), .ACC_W(10)) dut10 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready10),
    .a(a), .b(b), .mul_a(mul_a10), .mul_b(mul_b10), .mul_p(mul_p10),
    .out_valid(out_valid10), .out_ready(out_ready), .out_sum(out_sum10), .overflow(overflow10)
  );

  typedef struct {
    string      name;
    logic [3:0] av;
    logic [3:0] bv;
    bit         kmode;
    int         gap;
    int         hold;
    int         exp_sum;
    int         exp_ovf;
    int         exp_sum10;
    int         exp_ovf10;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents pairs until n have been accepted; returns 1 time unit after the last accept edge.
  task automatic send_pairs(input int n, input logic [3:0] av, input logic [3:0] bv,
                            input bit kmode, input int gap);
    int cnt = 0;
    int guard = 0;
    bit acc_now;
    while (cnt < n && guard < 400) begin
      if (int'($urandom_range(0, 99)) < gap) begin
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
      end else begin
        in_valid = 1'b1;
        a = kmode ? 4'(cnt) : av;
        b = kmode ? 4'(cnt) : bv;
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc_now) cnt++;
      guard++;
    end
    if (cnt < n) chk("send_timeout", cnt, n);
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    int lat;
    v = tbl[idx];
    out_ready = (v.hold == 0);
    send_pairs(16, v.av, v.bv, v.kmode, v.gap);
    in_valid = 1'b0;
    #1;
    chk({v.name, "_in_ready_drop"}, int'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({v.name, "_latency"}, lat, 2);
    chk({v.name, "_sum"}, int'(out_sum), v.exp_sum);
    chk({v.name, "_ovf"}, int'(overflow), v.exp_ovf);
    chk({v.name, "_valid10"}, int'(out_valid10), 1);
    chk({v.name, "_sum10"}, int'(out_sum10), v.exp_sum10);
    chk({v.name, "_ovf10"}, int'(overflow10), v.exp_ovf10);
    for (int i = 0; i < v.hold; i++) begin
      in_valid = (i % 2 == 0);
      a = 4'd15;
      b = 4'd15;
      @(posedge clk);
      #1;
      chk({v.name, "_hold_valid"}, int'(out_valid), 1);
      chk({v.name, "_hold_sum"}, int'(out_sum), v.exp_sum);
      chk({v.name, "_hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({v.name, "_post_valid"}, int'(out_valid), 0);
    chk({v.name, "_post_in_ready"}, int'(in_ready), 1);
    chk({v.name, "_post_sum"}, int'(out_sum), 0);
    chk({v.name, "_post_sum10"}, int'(out_sum10), 0);
    chk({v.name, "_post_ovf10"}, int'(overflow10), 0);
    $display("frame %s: sum=%0d ovf=%0d sum10=%0d latency=%0d", v.name, v.exp_sum, v.exp_ovf,
             v.exp_sum10, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"sq15",    4'd15, 4'd15, 1'b0,  0, 0, 3600, 0, 528, 1};
    tbl[1] = '{"kk",      4'd0,  4'd0,  1'b1,  0, 0, 1240, 0, 216, 1};
    tbl[2] = '{"kk_gap",  4'd0,  4'd0,  1'b1, 40, 5, 1240, 0, 216, 1};
    tbl[3] = '{"ones",    4'd1,  4'd1,  1'b0,  0, 0,   16, 0,  16, 0};
    tbl[4] = '{"two3",    4'd2,  4'd3,  1'b0,  0, 0,   96, 0,  96, 0};
    tbl[5] = '{"one15",   4'd1,  4'd15, 1'b0, 25, 0,  240, 0, 240, 0};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_overflow", int'(overflow), 0);

    for (int i = 0; i < 4; i++) run_frame(i);

    // Reset after seven accepted 2x3 pairs: six products are already summed.
    send_pairs(7, 4'd2, 4'd3, 1'b0, 0);
    chk("pre_rst_acc", int'(out_sum), 36);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_mul_a", int'(mul_a), 0);
    chk("mid_rst_mul_b", int'(mul_b), 0);
    chk("mid_rst_sum", int'(out_sum), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("mid_rst_dropped_op", int'(out_sum), 0);
    $display("seq mid_rst: 7 pairs then rst, acc cleared");
    run_frame(4);

    // Clear while pair 10 is presented and pair 9 is still in flight.
    send_pairs(9, 4'd1, 4'd15, 1'b0, 0);
    chk("pre_clr_acc", int'(out_sum), 120);
    in_valid = 1'b1;
    a = 4'd7;
    b = 4'd7;
    clr = 1'b1;
    #1;
    chk("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_sum", int'(out_sum), 0);
    chk("clr_mul_a", int'(mul_a), 0);
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_in_ready_after", int'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("clr_dropped_op", int'(out_sum), 0);
    $display("seq clr: 9 pairs then clr with pair 10 presented, acc cleared");
    run_frame(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
